// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-master round-robin arbiter in front of a single cache port
// One transaction in flight at a time: IDLE grants, ISSUE strobes, WAIT for cache_ready, DONE pulses ready.
module cache_port_arbiter #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic                     m0_rd,
    input  logic                     m0_wr,
    input  logic [3:0]               m0_byte_enable,
    input  logic [31:0]              m0_data_wr,
    output logic [31:0]              m0_data_out,
    output logic                     m0_ready,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic                     m1_rd,
    input  logic                     m1_wr,
    input  logic [3:0]               m1_byte_enable,
    input  logic [31:0]              m1_data_wr,
    output logic [31:0]              m1_data_out,
    output logic                     m1_ready,
    output logic [ADDRESS_WIDTH-1:0] cache_address,
    output logic                     cache_rd,
    output logic                     cache_wr,
    output logic [3:0]               cache_byte_enable,
    output logic [31:0]              cache_data_wr,
    input  logic [31:0]              cache_data_out,
    input  logic                     cache_ready,
    output logic                     grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_last_served;
    logic                     r_grant_id;
    logic                     r_op_wr;
    logic                     r_cache_rd;
    logic                     r_cache_wr;
    logic [ADDRESS_WIDTH-1:0] r_cache_address;
    logic [3:0]               r_cache_byte_enable;
    logic [31:0]              r_cache_data_wr;
    logic [31:0]              r_m0_data_out;
    logic [31:0]              r_m1_data_out;
    logic                     r_m0_ready;
    logic                     r_m1_ready;
    logic                     r_busy;

    logic                     w_pend0;
    logic                     w_pend1;
    logic                     w_grant_valid;
    logic                     w_grant_sel;
    logic                     w_complete;
    logic [ADDRESS_WIDTH-1:0] w_sel_address;
    logic [3:0]               w_sel_byte_enable;
    logic [31:0]              w_sel_data_wr;
    logic                     w_sel_wr;

    assign w_pend0 = m0_rd | m0_wr;
    assign w_pend1 = m1_rd | m1_wr;

    // rd+wr together collapses to a write, so only the wr bit matters for the op
    assign w_sel_address     = w_grant_sel ? m1_address     : m0_address;
    assign w_sel_byte_enable = w_grant_sel ? m1_byte_enable : m0_byte_enable;
    assign w_sel_data_wr     = w_grant_sel ? m1_data_wr     : m0_data_wr;
    assign w_sel_wr          = w_grant_sel ? m1_wr          : m0_wr;
    assign w_complete        = (r_state == S_WAIT) && cache_ready;

    always_comb begin
        w_next        = r_state;
        w_grant_valid = 1'b0;
        w_grant_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_grant_valid = 1'b1;
                    w_grant_sel   = (w_pend0 && w_pend1) ? ~r_last_served : w_pend1;
                    w_next        = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (cache_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served       <= 1'b1;
            r_grant_id          <= 1'b0;
            r_op_wr             <= 1'b0;
            r_cache_rd          <= 1'b0;
            r_cache_wr          <= 1'b0;
            r_cache_address     <= '0;
            r_cache_byte_enable <= '0;
            r_cache_data_wr     <= '0;
            r_m0_data_out       <= '0;
            r_m1_data_out       <= '0;
            r_m0_ready          <= 1'b0;
            r_m1_ready          <= 1'b0;
            r_busy              <= 1'b0;
        end else begin
            r_cache_rd <= 1'b0;
            r_cache_wr <= 1'b0;
            r_m0_ready <= w_complete && !r_grant_id;
            r_m1_ready <= w_complete &&  r_grant_id;
            r_busy     <= (w_next != S_IDLE);
            if (w_grant_valid) begin
                r_grant_id          <= w_grant_sel;
                r_last_served       <= w_grant_sel;
                r_op_wr             <= w_sel_wr;
                r_cache_rd          <= ~w_sel_wr;
                r_cache_wr          <= w_sel_wr;
                r_cache_address     <= w_sel_address;
                r_cache_byte_enable <= w_sel_byte_enable;
                r_cache_data_wr     <= w_sel_data_wr;
            end
            if (w_complete && !r_op_wr) begin
                if (r_grant_id) r_m1_data_out <= cache_data_out;
                else            r_m0_data_out <= cache_data_out;
            end
        end
    end

    assign cache_address     = r_cache_address;
    assign cache_rd          = r_cache_rd;
    assign cache_wr          = r_cache_wr;
    assign cache_byte_enable = r_cache_byte_enable;
    assign cache_data_wr     = r_cache_data_wr;
    assign m0_data_out       = r_m0_data_out;
    assign m1_data_out       = r_m1_data_out;
    assign m0_ready          = r_m0_ready;
    assign m1_ready          = r_m1_ready;
    assign grant_id          = r_grant_id;
    assign busy              = r_busy;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - randomized scoreboard bench for cache_port_arbiter
module tb_cache_port_arbiter;
    localparam int AW      = 16;
    localparam int MAX_CYC = 20000;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
        int            not_before;
        int            gap;
    } txn_t;

    typedef struct {
        int            cyc;
        logic          m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } cache_exp_t;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] d0;
        logic [31:0] d1;
    } ready_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_address, m1_address;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [3:0]    m0_byte_enable, m1_byte_enable;
    logic [31:0]   m0_data_wr, m1_data_wr, m0_data_out, m1_data_out;
    logic          m0_ready, m1_ready;
    logic [AW-1:0] cache_address;
    logic          cache_rd, cache_wr;
    logic [3:0]    cache_byte_enable;
    logic [31:0]   cache_data_wr, cache_data_out;
    logic          cache_ready;
    logic          grant_id, busy;

    cache_port_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_byte_enable(m0_byte_enable), .m0_data_wr(m0_data_wr),
        .m0_data_out(m0_data_out), .m0_ready(m0_ready),
        .m1_address(m1_address), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_byte_enable(m1_byte_enable), .m1_data_wr(m1_data_wr),
        .m1_data_out(m1_data_out), .m1_ready(m1_ready),
        .cache_address(cache_address), .cache_rd(cache_rd), .cache_wr(cache_wr),
        .cache_byte_enable(cache_byte_enable), .cache_data_wr(cache_data_wr),
        .cache_data_out(cache_data_out), .cache_ready(cache_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    cache_exp_t  cq[$];
    ready_exp_t  rq[$];
    txn_t        q0[$];
    txn_t        q1[$];
    txn_t        cur[2];
    logic        pend[2];
    logic        granted[2];
    int          idle_since[2];
    int          done_cyc[2];
    logic [31:0] dout[2];
    bit          busy_exp[MAX_CYC + 64];

    // Transaction-level model of the arbiter: who is served next and when the port frees up
    logic        last      = 1'b1;
    int          free_at   = 3;
    int          n_grant   = 0;
    int          force_lat = 0;
    logic        resp_pend = 1'b0;
    int          resp_cyc  = 0;
    logic [31:0] resp_data = 32'h0;
    int          wait_lo   = -10;
    int          wait_hi   = -10;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void flag(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endfunction

    function automatic txn_t mk(logic rd, logic wr, logic [AW-1:0] addr, logic [3:0] be,
                                logic [31:0] data, int nb, int gap);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.be = be; t.data = data;
        t.not_before = nb; t.gap = gap;
        return t;
    endfunction

    function automatic txn_t mk_rand(int nb, int gap);
        logic [1:0] op;
        op = 2'($urandom_range(1, 3));
        return mk(op[0], op[1], AW'($urandom), 4'($urandom), $urandom, nb, gap);
    endfunction

    task automatic drive_masters();
        m0_rd = pend[0] & cur[0].rd;  m0_wr = pend[0] & cur[0].wr;
        m0_address = cur[0].addr;     m0_byte_enable = cur[0].be;  m0_data_wr = cur[0].data;
        m1_rd = pend[1] & cur[1].rd;  m1_wr = pend[1] & cur[1].wr;
        m1_address = cur[1].addr;     m1_byte_enable = cur[1].be;  m1_data_wr = cur[1].data;
    endtask

    // Drives every input for the current cycle and advances the reference model.
    task automatic step(input bit do_rst, input bit stray);
        int          c;
        logic        w;
        int          lat;
        int          rc;
        logic [31:0] rdata;
        c = cyc;
        if (do_rst) begin
            rst = 1'b1;
            for (int m = 0; m < 2; m++) begin
                pend[m] = 1'b0; granted[m] = 1'b0; idle_since[m] = c;
            end
            while (cq.size() != 0 && cq[$].cyc > c) void'(cq.pop_back());
            while (rq.size() != 0 && rq[$].cyc > c) void'(rq.pop_back());
            for (int k = c + 1; k < MAX_CYC + 64; k++) busy_exp[k] = 1'b0;
            free_at = c + 1; last = 1'b1; dout[0] = '0; dout[1] = '0;
            resp_pend = 1'b0; wait_lo = -10; wait_hi = -10;
            drive_masters();
            cache_ready = 1'b0;
            cache_data_out = $urandom;
            return;
        end
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (pend[m] && done_cyc[m] == c - 1) begin
                pend[m] = 1'b0; granted[m] = 1'b0; idle_since[m] = c;
            end
        end
        if (!pend[0] && q0.size() != 0 && c >= idle_since[0] + q0[0].gap && c >= q0[0].not_before) begin
            cur[0] = q0.pop_front(); pend[0] = 1'b1;
        end
        if (!pend[1] && q1.size() != 0 && c >= idle_since[1] + q1[1 - 1].gap && c >= q1[0].not_before) begin
            cur[1] = q1.pop_front(); pend[1] = 1'b1;
        end
        // an in-flight master may wiggle its fields; the cache side must not follow
        for (int m = 0; m < 2; m++) begin
            if (granted[m] && $urandom_range(0, 1) == 1) begin
                cur[m].addr = AW'($urandom); cur[m].be = 4'($urandom); cur[m].data = $urandom;
            end
        end
        drive_masters();
        if (c >= free_at && (pend[0] || pend[1])) begin
            w     = (pend[0] && pend[1]) ? ~last : pend[1];
            last  = w;
            lat   = (force_lat != 0) ? force_lat : ((n_grant < 4) ? 2 : int'($urandom_range(1, 4)));
            rc    = c + 1 + lat;
            rdata = $urandom;
            cq.push_back('{c + 1, w, cur[w].wr, cur[w].addr, cur[w].be, cur[w].data});
            if (!cur[w].wr) dout[w] = rdata;
            rq.push_back('{rc + 1, w, dout[0], dout[1]});
            for (int k = c + 1; k <= rc + 1; k++) busy_exp[k] = 1'b1;
            free_at     = rc + 2;
            done_cyc[w] = rc + 1;
            granted[w]  = 1'b1;
            n_grant++;
            resp_pend = 1'b1; resp_cyc = rc; resp_data = rdata;
            wait_lo = c + 2;  wait_hi = rc;
        end
        cache_data_out = $urandom;
        if (resp_pend && c == resp_cyc) begin
            cache_ready = 1'b1; cache_data_out = resp_data; resp_pend = 1'b0;
        end else if (c >= wait_lo && c <= wait_hi) begin
            cache_ready = 1'b0;
        end else begin
            cache_ready = stray || ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or a ready pulse
    initial begin
        cache_exp_t ce;
        cache_exp_t hv;
        ready_exp_t re;
        int         c;
        logic       rst_d;
        logic       hold;
        rst_d = 1'b1;
        hold  = 1'b0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c >= 1) begin
                if (rst_d) begin
                    check("rst_cache_rd", 64'(cache_rd), 64'(0));
                    check("rst_cache_wr", 64'(cache_wr), 64'(0));
                    check("rst_ready", 64'({m1_ready, m0_ready}), 64'(0));
                    check("rst_grant_id", 64'(grant_id), 64'(0));
                    check("rst_addr", 64'(cache_address), 64'(0));
                    check("rst_be", 64'(cache_byte_enable), 64'(0));
                    check("rst_wdata", 64'(cache_data_wr), 64'(0));
                    check("rst_dout0", 64'(m0_data_out), 64'(0));
                    check("rst_dout1", 64'(m1_data_out), 64'(0));
                    hold = 1'b0;
                end
                if (hold) begin
                    check("hold_addr", 64'(cache_address), 64'(hv.addr));
                    check("hold_be", 64'(cache_byte_enable), 64'(hv.be));
                    check("hold_wdata", 64'(cache_data_wr), 64'(hv.data));
                    check("hold_grant", 64'(grant_id), 64'(hv.m));
                end
                if (cache_rd || cache_wr) begin
                    if (cq.size() == 0) begin
                        flag("unexpected_strobe");
                    end else begin
                        ce = cq.pop_front();
                        check("strobe_cycle", 64'(c), 64'(ce.cyc));
                        check("strobe_grant", 64'(grant_id), 64'(ce.m));
                        check("strobe_op", 64'({cache_rd, cache_wr}), 64'({~ce.wr, ce.wr}));
                        check("strobe_addr", 64'(cache_address), 64'(ce.addr));
                        check("strobe_be", 64'(cache_byte_enable), 64'(ce.be));
                        check("strobe_wdata", 64'(cache_data_wr), 64'(ce.data));
                        hv = ce;
                        hold = 1'b1;
                    end
                end else if (cq.size() != 0 && cq[0].cyc <= c) begin
                    flag("missing_strobe");
                    void'(cq.pop_front());
                end
                if (m0_ready || m1_ready) begin
                    if (rq.size() == 0) begin
                        flag("unexpected_ready");
                    end else begin
                        re = rq.pop_front();
                        check("ready_cycle", 64'(c), 64'(re.cyc));
                        check("ready_lines", 64'({m1_ready, m0_ready}), 64'(re.m ? 2'b10 : 2'b01));
                        check("dout0", 64'(m0_data_out), 64'(re.d0));
                        check("dout1", 64'(m1_data_out), 64'(re.d1));
                        hold = 1'b0;
                    end
                end else if (rq.size() != 0 && rq[0].cyc <= c) begin
                    flag("missing_ready");
                    void'(rq.pop_front());
                end
                if (c < MAX_CYC + 64) check("busy", 64'(busy), 64'(busy_exp[c]));
            end
            rst_d = rst;
        end
    end

    initial begin
        int s;
        rst = 1'b1;
        cache_ready = 1'b0;
        cache_data_out = '0;
        for (int m = 0; m < 2; m++) begin
            cur[m] = mk(1'b0, 1'b0, '0, '0, '0, 0, 0);
            pend[m] = 1'b0; granted[m] = 1'b0; idle_since[m] = 0; done_cyc[m] = -10; dout[m] = '0;
        end
        drive_masters();

        // simultaneous request straight after reset: master 0 must win
        q0.push_back(mk(1'b1, 1'b0, 16'h0100, 4'hF, 32'h0, 3, 0));
        q1.push_back(mk(1'b0, 1'b1, 16'h0200, 4'hF, 32'h12345678, 3, 0));
        // lone read with a two-cycle cache response
        q0.push_back(mk(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 30, 0));
        // rd and wr together is a write
        q1.push_back(mk(1'b1, 1'b1, 16'h0044, 4'h3, 32'hCAFE0044, 45, 0));
        // both masters hold requests back to back
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk_rand(i == 0 ? 60 : 0, 0));
            q1.push_back(mk_rand(i == 0 ? 60 : 0, 0));
        end
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk_rand(0, int'($urandom_range(0, 3))));
            q1.push_back(mk_rand(0, int'($urandom_range(0, 3))));
        end

        do tick(); while (cyc < 3);

        while ((q0.size() != 0 || q1.size() != 0 || pend[0] || pend[1] || cyc < free_at)
               && cyc < MAX_CYC - 200) begin
            step(1'b0, 1'b0);
            tick();
        end
        if (cyc >= MAX_CYC - 200) flag("timeout_traffic");

        // reset lands in the middle of a long WAIT, followed by a stray cache_ready
        force_lat = 6;
        q0.push_back(mk(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 0, 0));
        s = n_grant;
        while (n_grant == s && cyc < MAX_CYC - 100) begin
            step(1'b0, 1'b0);
            tick();
        end
        if (n_grant == s) flag("timeout_reset_grant");
        step(1'b0, 1'b0); tick();
        step(1'b0, 1'b0); tick();
        step(1'b1, 1'b0); tick();
        step(1'b0, 1'b1); tick();
        force_lat = 0;
        repeat (8) begin
            step(1'b0, 1'b0);
            tick();
        end
        @(negedge clk);
        check("cache_q_drained", 64'(cq.size()), 64'(0));
        check("ready_q_drained", 64'(rq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
